// File: rtl/icache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_if : fetch-side and refill-side signal bundle for icache      |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
interface icache_if;
    logic        rdy;
    logic        rob_clear;
    logic        start_fetch;
    logic [31:0] pc;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    // Cache side: answers the Fetcher, issues refills to memory.
    modport slave (
        input  rdy, rob_clear, start_fetch, pc, mem_ready, mem_data,
        output instr_ready, instr, instr_addr, mem_req, mem_addr
    );

    // Environment side: Fetcher, RoB and memory controller.
    modport master (
        output rdy, rob_clear, start_fetch, pc, mem_ready, mem_data,
        input  instr_ready, instr, instr_addr, mem_req, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache : direct-mapped, one-word-per-line instruction cache          |
// |          with single outstanding refill and flush-abort support      |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module icache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);

    localparam int LINES = 2 ** INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_MISS = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic        instr_ready_q, instr_ready_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_addr_q, instr_addr_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        aborted_q, aborted_d;
    logic [31:0] req_pc_q, req_pc_d;

    logic                   fill_en;
    logic [INDEX_WIDTH-1:0] pc_idx;
    logic [TAG_W-1:0]       pc_tag;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic                   lookup_hit;
    logic                   pc_moved;

    assign pc_idx     = bus.pc[INDEX_WIDTH+1:2];
    assign pc_tag     = bus.pc[31:INDEX_WIDTH+2];
    assign req_idx    = req_pc_q[INDEX_WIDTH+1:2];
    assign req_tag    = req_pc_q[31:INDEX_WIDTH+2];
    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    // The Fetcher has moved on to another address while the refill is in flight.
    assign pc_moved   = bus.start_fetch && (bus.pc != req_pc_q);

    always_comb begin
        state_d       = state_q;
        instr_ready_d = 1'b0;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        aborted_d     = aborted_q;
        req_pc_d      = req_pc_q;
        fill_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_fetch && !bus.rob_clear) begin
                    if (lookup_hit) begin
                        instr_ready_d = 1'b1;
                        instr_d       = data_q[pc_idx];
                        instr_addr_d  = bus.pc;
                        state_d       = S_RESP;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.pc[31:2], 2'b00};
                        req_pc_d   = bus.pc;
                        aborted_d  = 1'b0;
                        state_d    = S_MISS;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            S_MISS: begin
                if (!bus.mem_ready) begin
                    if (bus.rob_clear || pc_moved) begin
                        aborted_d = 1'b1;
                    end
                end else begin
                    // The line is filled even when delivery was aborted.
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    if (!aborted_q && !bus.rob_clear && !pc_moved) begin
                        instr_ready_d = 1'b1;
                        instr_d       = bus.mem_data;
                        instr_addr_d  = req_pc_q;
                        state_d       = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_ready_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_addr_q  <= 32'h0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            aborted_q     <= 1'b0;
            req_pc_q      <= 32'h0;
            valid_q       <= '0;
        end else if (bus.rdy) begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            aborted_q     <= aborted_d;
            req_pc_q      <= req_pc_d;
            if (fill_en) begin
                valid_q[req_idx] <= 1'b1;
            end
        end
    end

    // Tag and data are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && fill_en) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= bus.mem_data;
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_icache : self-checking bench for icache                           |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
module tb_icache;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_if bus();

    icache #(.INDEX_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc       = 0;
    int n_pass    = 0;
    int n_total   = 0;
    int mem_lat   = 3;
    int ready_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0513;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Memory controller: pulses mem_ready mem_lat sampled cycles after seeing mem_req.
    initial begin
        logic r, rs, mr;
        int   cnt;
        cnt           = 0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = 32'h0;
        forever begin
            @(posedge clk);
            r  = bus.rdy;
            rs = rst;
            mr = bus.mem_ready;
            #1;
            if (rs) begin
                cnt           = 0;
                bus.mem_ready = 1'b0;
            end else if (r) begin
                if (mr) begin
                    bus.mem_ready = 1'b0;
                end else if (bus.mem_req) begin
                    cnt++;
                    if (cnt >= mem_lat) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_data  = memfn(bus.mem_addr);
                        ready_cyc     = cyc;
                        cnt           = 0;
                    end
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input bit exp_hit,
                            input logic [31:0] exp_instr, input bit clr_first);
        bit    seen_req;
        bit    got;
        string p;
        seen_req = 1'b0;
        got      = 1'b0;
        p        = $sformatf("pc%08h_", a);
        if (clr_first) begin
            bus.start_fetch = 1'b1;
            bus.pc          = a;
            bus.rob_clear   = 1'b1;
            @(negedge clk);
            chk({p, "clr_no_resp"}, 32'(bus.instr_ready), 32'h0);
            chk({p, "clr_no_req"}, 32'(bus.mem_req), 32'h0);
            bus.rob_clear = 1'b0;
        end
        bus.start_fetch = 1'b1;
        bus.pc          = a;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (n == 0) begin
                chk({p, "first_resp"}, 32'(bus.instr_ready), 32'(exp_hit));
                chk({p, "first_req"}, 32'(bus.mem_req), 32'(!exp_hit));
            end
            if (bus.mem_req && !seen_req) begin
                seen_req = 1'b1;
                chk({p, "mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
            end
            if (bus.instr_ready) begin
                got = 1'b1;
                chk({p, "instr"}, bus.instr, exp_instr);
                chk({p, "instr_addr"}, bus.instr_addr, a);
                if (!exp_hit) chk({p, "miss_latency"}, 32'(cyc), 32'(ready_cyc + 1));
            end
        end
        chk({p, "resp_seen"}, 32'(got), 32'h1);
        bus.start_fetch = 1'b0;
        @(negedge clk);
        chk({p, "pulse_end"}, 32'(bus.instr_ready), 32'h0);
        chk({p, "req_idle"}, 32'(bus.mem_req), 32'h0);
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          hit;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit   got, seen80;
        bit   mv [8];
        int   mt [8];
        int   tg, ix;
        bit   hit, clr;
        logic [31:0] rp;

        rst             = 1'b1;
        bus.rdy         = 1'b1;
        bus.rob_clear   = 1'b0;
        bus.start_fetch = 1'b0;
        bus.pc          = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_instr_ready", 32'(bus.instr_ready), 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_addr", bus.instr_addr, 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss, hit, conflicts on index 0 and 1, top index, unaligned pc.
        tbl[0]  = '{32'h0000_0000, 1'b0, 32'h0000_0513};
        tbl[1]  = '{32'h0000_0000, 1'b1, 32'h0000_0513};
        tbl[2]  = '{32'h0000_0100, 1'b0, memfn(32'h100)};
        tbl[3]  = '{32'h0000_0000, 1'b0, 32'h0000_0513};
        tbl[4]  = '{32'h0000_0100, 1'b0, memfn(32'h100)};
        tbl[5]  = '{32'h0000_0004, 1'b0, memfn(32'h004)};
        tbl[6]  = '{32'h0000_0004, 1'b1, memfn(32'h004)};
        tbl[7]  = '{32'h0000_0107, 1'b0, memfn(32'h104)};
        tbl[8]  = '{32'h0000_0104, 1'b1, memfn(32'h104)};
        tbl[9]  = '{32'h0000_00FC, 1'b0, memfn(32'h0FC)};
        tbl[10] = '{32'h0000_00FC, 1'b1, memfn(32'h0FC)};
        tbl[11] = '{32'h0000_0004, 1'b0, memfn(32'h004)};
        for (int i = 0; i < 12; i++) begin
            do_fetch(tbl[i].pc, tbl[i].hit, tbl[i].instr, 1'b0);
        end

        // rdy stall on a hit response.
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_00FC;
        @(negedge clk);
        chk("stall_resp", 32'(bus.instr_ready), 32'h1);
        bus.rdy         = 1'b0;
        bus.start_fetch = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_hold_ready", 32'(bus.instr_ready), 32'h1);
            chk("stall_hold_instr", bus.instr, memfn(32'h0FC));
            chk("stall_hold_addr", bus.instr_addr, 32'h0000_00FC);
        end
        bus.rdy = 1'b1;
        @(negedge clk);
        chk("stall_release", 32'(bus.instr_ready), 32'h0);
        chk("stall_instr_kept", bus.instr, memfn(32'h0FC));

        // Flush mid-miss, then the Fetcher redirects to 0x80.
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_0040;
        @(negedge clk);
        chk("flush_req", 32'(bus.mem_req), 32'h1);
        chk("flush_addr", bus.mem_addr, 32'h0000_0040);
        bus.rob_clear   = 1'b1;
        bus.start_fetch = 1'b0;
        @(negedge clk);
        bus.rob_clear   = 1'b0;
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_0080;
        got    = 1'b0;
        seen80 = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_addr == 32'h0000_0080) seen80 = 1'b1;
            if (bus.instr_ready) begin
                got = 1'b1;
                chk("flush_resp_addr", bus.instr_addr, 32'h0000_0080);
                chk("flush_resp_instr", bus.instr, memfn(32'h080));
            end
        end
        chk("flush_resp_seen", 32'(got), 32'h1);
        chk("flush_refill_80", 32'(seen80), 32'h1);
        bus.start_fetch = 1'b0;
        @(negedge clk);
        do_fetch(32'h0000_0040, 1'b1, memfn(32'h040), 1'b0);

        // Reset during a miss clears the line array.
        do_fetch(32'h0000_0000, 1'b0, 32'h0000_0513, 1'b0);
        do_fetch(32'h0000_0000, 1'b1, 32'h0000_0513, 1'b0);
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_0008;
        @(negedge clk);
        chk("rstmiss_req", 32'(bus.mem_req), 32'h1);
        rst             = 1'b1;
        bus.start_fetch = 1'b0;
        @(negedge clk);
        chk("rstmiss_instr_ready", 32'(bus.instr_ready), 32'h0);
        chk("rstmiss_instr", bus.instr, 32'h0);
        chk("rstmiss_instr_addr", bus.instr_addr, 32'h0);
        chk("rstmiss_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rstmiss_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(32'h0000_0000, 1'b0, 32'h0000_0513, 1'b0);

        // Random traffic over 8 indices x 4 tags against a valid/tag model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            mt[i] = 0;
        end
        for (int k = 0; k < 150; k++) begin
            tg      = int'($urandom_range(0, 3));
            ix      = int'($urandom_range(0, 7));
            rp      = (32'(tg) << 8) | (32'(ix) << 2);
            mem_lat = int'($urandom_range(1, 5));
            clr     = ($urandom_range(0, 7) == 0);
            hit     = mv[ix] && (mt[ix] == tg);
            do_fetch(rp, hit, memfn(rp), clr);
            mv[ix] = 1'b1;
            mt[ix] = tg;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
